core_pipe_ff: RTL and testbench
===============================

# core_pipe_ff

Parametrised elastic register pipeline: a chain of `Depth` enable-gated data registers, each `Bits` wide, with valid/ready handshaking, bubble collapsing, synchronous flush and an occupancy count. It is the general-purpose successor to the single enable flip-flop. Datapath stages throughout the MNIST pipeline use it to add latency without losing throughput or dropping data under back-pressure.

## Interface
Parameters:
- `Bits`, default 1: data width per stage; must be ≥1.
- `Depth`, default 2: number of register stages; must be ≥1.
- `CountBits`, localparam = `$clog2(Depth+1)`: width of `count_o`.

Ports:
- `clk_i`, input, 1: single clock; all state updates on its rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `flush_i`, input, 1: synchronous discard of all held entries.
- `valid_i`, input, 1: upstream data valid.
- `ready_o`, output, 1: the pipeline accepts `data_i` this cycle.
- `data_i`, input, `Bits`: upstream data.
- `valid_o`, output, 1: `data_o` is valid.
- `ready_i`, input, 1: downstream accepts `data_o` this cycle.
- `data_o`, output, `Bits`: data from stage `Depth-1`.
- `count_o`, output, `CountBits`: number of valid stages.

## Operation
- State per stage s (0 = input side, `Depth-1` = output side): `vld[s]` and `dat[s]`.
- Enable chain:
  - `en[Depth] = ready_i`.
  - `en[s] = ~vld[s] | en[s+1]`.
  - The chain is combinational and bubble-collapsing: an empty stage always accepts, even while downstream is stalled.
- Stage update when `en[s]`:
  - `vld[s] <= upstream_valid`, where upstream is `valid_i` for s=0 and `vld[s-1]` otherwise.
  - `dat[s] <= upstream_data` only when `upstream_valid` is 1. When it is 0, the data is held, to reduce toggling.
- When `en[s]=0`, the stage holds its contents.
- Outputs:
  - `ready_o = en[0] & ~flush_i`.
  - `valid_o = vld[Depth-1] & ~flush_i`.
  - `data_o = dat[Depth-1]`.
  - `count_o` = population count of `vld`, taken from registers only.
- Transfer rules: an input transfer occurs when `valid_i & ready_o`. An output transfer occurs when `valid_o & ready_i`.
- `data_i` is ignored when `valid_i=0`. A valid entry is never overwritten or dropped except by flush or reset.
- Flush (`flush_i=1`):
  - All `vld` are cleared on the next edge; `dat` is untouched.
  - No input or output transfer occurs in the flush cycle.
  - Flush takes priority over all handshakes.
- Reset (`rst_i=1`):
  - All `vld` cleared and all `dat` set to 0 on the next edge. This overrides flush and handshakes.
  - After that edge: `valid_o=0`, `data_o=0`, `count_o=0`.
  - `ready_o=1` once `rst_i` is low and `flush_i` is low.
- Boundary cases:
  - Full (`count_o=Depth`), `ready_i=1`, `valid_i=1`: input and output transfer in the same cycle, and the count is unchanged.
  - Full with `ready_i=0`: `ready_o=0`.
  - Empty, `valid_i=1`: the entry is accepted, and `count_o` increments on the next edge.
  - Reset asserted mid-stream: all in-flight entries are lost, with no partial outputs.

## Timing
- Latency: an entry accepted at edge k appears on `valid_o` after edge k+`Depth`-1, i.e. `Depth` register stages. This holds when no stall occurs.
- Throughput: one entry per cycle while `ready_i=1`.
- Combinational paths:
  - `ready_i` → `ready_o`, through `Depth` OR gates.
  - `flush_i` → `ready_o` and `flush_i` → `valid_o`.
  - No path from `data_i` or `valid_i` to any output.
- A stall of N cycles on `ready_i` delays every held entry by exactly N cycles, and empty stages fill during the stall.
- `count_o` updates on the edge after the transfer.

## Structure
- No shared package entries are needed. `CountBits` is a local parameter.
- One sub-module is natural: `core_pipe_stage`, a single `Bits`-wide stage.
  - Ports: `clk_i`, `rst_i`, `flush_i`, `en_i`, `vld_i`, `dat_i`, `vld_o`, `dat_o`.
  - The top level instantiates it with a generate loop over `Depth` and builds the enable chain.
- Popcount is done in the top level as a simple loop.

## Test plan
- Reset then stream, `Depth=3`, `Bits=8`, `ready_i=1`: drive 0x01..0x05 on consecutive cycles. Required: `data_o` shows 0x01..0x05 on consecutive cycles starting 3 edges after the first accept, and `count_o` reaches 3 and holds.
- Back-pressure, `Depth=3`: fill with 0xA0, 0xA1, 0xA2, then drop `ready_i` for 4 cycles with `valid_i=1`. Required: `ready_o=0`, `count_o=3`, and `data_o` holds 0xA0. On release, 0xA0, 0xA1, 0xA2 then the new data emerge in order, with no loss or duplication.
- Bubble collapse, `Depth=4`: inject 0x11, one idle cycle, then 0x22, with `ready_i=0`. Required: both entries packed at the output end, `count_o=2`, `ready_o=1`.
- Flush, `Depth=2`: hold 2 entries, assert `flush_i` for 1 cycle with `valid_i=1`. Required: `ready_o=0` and `valid_o=0` during the flush cycle, `count_o=0` afterwards, and the flushed data never appears.
- Reset mid-stream, `Depth=2`: hold 2 entries, assert `rst_i` for 1 cycle concurrently with `flush_i` and `valid_i`. Required: `valid_o=0`, `data_o=0`, `count_o=0` after the edge, and the next accepted entry appears after 2 edges.
- Edge configuration `Depth=1`, `Bits=1`: random `valid_i`/`ready_i` for 1000 cycles, checked against a scoreboard. Required: exact in-order delivery and `count_o` ∈ {0, 1}.

Source files
------------

// File: rtl/core_pipe_ff_pkg.sv
// -----------------------------------------------------------------------------
// core_pipe_ff_pkg
// Shared helpers for the elastic register pipeline.
//   stage_en : the enable term of one stage in the bubble-collapsing chain.
//              A stage may load when it is empty or when the stage after it
//              is loading as well.
// -----------------------------------------------------------------------------
package core_pipe_ff_pkg;

    function automatic logic stage_en(input logic vld, input logic en_down);
        return (~vld) | en_down;
    endfunction

endpackage

// File: rtl/core_pipe_ff_stage.sv
// -----------------------------------------------------------------------------
// core_pipe_stage
// One enable-gated pipeline stage holding a valid bit and a Bits-wide word.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (clears valid, zeroes data)
//   flush_i : synchronous discard (clears valid, data untouched)
//   en_i    : stage load enable from the enable chain
//   vld_i   : upstream valid
//   dat_i   : upstream data
//   vld_o   : stage valid
//   dat_o   : stage data
// -----------------------------------------------------------------------------
module core_pipe_stage
    import core_pipe_ff_pkg::*;
#(
    parameter int Bits = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            en_i,
    input  logic            vld_i,
    input  logic [Bits-1:0] dat_i,
    output logic            vld_o,
    output logic [Bits-1:0] dat_o
);

    logic            r_vld;
    logic [Bits-1:0] r_dat;

    // Stage state: reset beats flush, flush beats the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (flush_i) begin
            r_vld <= 1'b0;
        end else if (en_i) begin
            r_vld <= vld_i;
            // Data only moves with a valid entry, so bubbles do not toggle it.
            if (vld_i) begin
                r_dat <= dat_i;
            end
        end
    end

    assign vld_o = r_vld;
    assign dat_o = r_dat;

endmodule

// File: rtl/core_pipe_ff.sv
// -----------------------------------------------------------------------------
// core_pipe_ff
// Elastic register pipeline of Depth stages, Bits wide, with valid/ready
// handshake, bubble collapsing, synchronous flush and occupancy count.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   flush_i : synchronous discard of all held entries
//   valid_i : upstream valid          ready_o : pipeline accepts data_i
//   data_i  : upstream data
//   valid_o : data_o is valid         ready_i : downstream accepts data_o
//   data_o  : data of the output-side stage
//   count_o : number of valid stages (from registers only)
// -----------------------------------------------------------------------------
module core_pipe_ff
    import core_pipe_ff_pkg::*;
#(
    parameter  int Bits      = 1,
    parameter  int Depth     = 2,
    localparam int CountBits = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [Bits-1:0]      data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [Bits-1:0]      data_o,
    output logic [CountBits-1:0] count_o
);

    logic [Depth:0]                w_en;
    logic [Depth-1:0]              w_vld;
    logic [Depth-1:0][Bits-1:0]    w_dat;
    logic [Depth-1:0]              w_up_vld;
    logic [Depth-1:0][Bits-1:0]    w_up_dat;
    logic [CountBits-1:0]          w_count;

    // Enable chain, output side first: an empty stage always loads, so
    // bubbles are squeezed out even while the output is stalled.
    always_comb begin
        w_en        = '0;
        w_en[Depth] = ready_i;
        for (int s = Depth - 1; s >= 0; s--) begin
            w_en[s] = stage_en(w_vld[s], w_en[s+1]);
        end
    end

    for (genvar s = 0; s < Depth; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign w_up_vld[s] = valid_i;
            assign w_up_dat[s] = data_i;
        end else begin : g_body
            assign w_up_vld[s] = w_vld[s-1];
            assign w_up_dat[s] = w_dat[s-1];
        end

        core_pipe_stage #(
            .Bits (Bits)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .en_i    (w_en[s]),
            .vld_i   (w_up_vld[s]),
            .dat_i   (w_up_dat[s]),
            .vld_o   (w_vld[s]),
            .dat_o   (w_dat[s])
        );
    end

    // Occupancy: population count of the stage valid registers.
    always_comb begin
        w_count = '0;
        for (int s = 0; s < Depth; s++) begin
            w_count = w_count + CountBits'(w_vld[s]);
        end
    end

    // Flush masks both handshakes so no transfer happens in the flush cycle.
    assign ready_o = w_en[0] & ~flush_i;
    assign valid_o = w_vld[Depth-1] & ~flush_i;
    assign data_o  = w_dat[Depth-1];
    assign count_o = w_count;

endmodule

// File: tb/tb_core_pipe_ff.sv
module tb_core_pipe_ff;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: Depth=3, Bits=8
    logic       a_flush, a_vi, a_ro, a_vo, a_ri;
    logic [7:0] a_di, a_do;
    logic [1:0] a_cnt;
    // Instance B: Depth=4, Bits=8
    logic       b_flush, b_vi, b_ro, b_vo, b_ri;
    logic [7:0] b_di, b_do;
    logic [2:0] b_cnt;
    // Instance C: Depth=2, Bits=8 (own reset)
    logic       c_rst, c_flush, c_vi, c_ro, c_vo, c_ri;
    logic [7:0] c_di, c_do;
    logic [1:0] c_cnt;
    // Instance D: Depth=1, Bits=1
    logic       d_flush, d_vi, d_ro, d_vo, d_ri;
    logic [0:0] d_di, d_do;
    logic [0:0] d_cnt;

    core_pipe_ff #(.Bits(8), .Depth(3)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .valid_i(a_vi), .ready_o(a_ro),
        .data_i(a_di), .valid_o(a_vo), .ready_i(a_ri), .data_o(a_do), .count_o(a_cnt));
    core_pipe_ff #(.Bits(8), .Depth(4)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .valid_i(b_vi), .ready_o(b_ro),
        .data_i(b_di), .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do), .count_o(b_cnt));
    core_pipe_ff #(.Bits(8), .Depth(2)) u_c (
        .clk_i(clk), .rst_i(c_rst), .flush_i(c_flush), .valid_i(c_vi), .ready_o(c_ro),
        .data_i(c_di), .valid_o(c_vo), .ready_i(c_ri), .data_o(c_do), .count_o(c_cnt));
    core_pipe_ff #(.Bits(1), .Depth(1)) u_d (
        .clk_i(clk), .rst_i(rst), .flush_i(d_flush), .valid_i(d_vi), .ready_o(d_ro),
        .data_i(d_di), .valid_o(d_vo), .ready_i(d_ri), .data_o(d_do), .count_o(d_cnt));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Test 1 tables, indexed by cycle c (state after edge c)
    int       t1_cnt [9] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
    logic     t1_vo  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int       t1_dat [9] = '{0, 0, 0, 1, 2, 3, 4, 5, 5};
    int       t2_out [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic     q[$];
    int       exp_q;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; c_rst = 1'b1;
        a_flush = 1'b0; a_vi = 1'b0; a_ri = 1'b1; a_di = 8'h00;
        b_flush = 1'b0; b_vi = 1'b0; b_ri = 1'b0; b_di = 8'h00;
        c_flush = 1'b0; c_vi = 1'b0; c_ri = 1'b0; c_di = 8'h00;
        d_flush = 1'b0; d_vi = 1'b0; d_ri = 1'b0; d_di = 1'b0;
        tick();
        rst = 1'b0; c_rst = 1'b0;
        #2;
        check_eq("rst_valid_o", 32'(a_vo), 32'd0);
        check_eq("rst_data_o", 32'(a_do), 32'd0);
        check_eq("rst_count_o", 32'(a_cnt), 32'd0);
        check_eq("rst_ready_o", 32'(a_ro), 32'd1);

        // ---- Test 1: stream 0x01..0x05 through Depth=3 ----
        for (int c = 0; c < 9; c++) begin
            a_vi = (c < 5);
            a_di = 8'(c + 1);
            a_ri = 1'b1;
            #2;
            check_eq("t1_ready_o", 32'(a_ro), 32'd1);
            check_eq("t1_count_o", 32'(a_cnt), 32'(t1_cnt[c]));
            check_eq("t1_valid_o", 32'(a_vo), 32'(t1_vo[c]));
            if (t1_vo[c]) check_eq("t1_data_o", 32'(a_do), 32'(t1_dat[c]));
            tick();
        end
        a_vi = 1'b0;

        // ---- Test 2: back-pressure on Depth=3 ----
        a_ri = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a_vi = 1'b1;
            a_di = 8'hA0 + 8'(c);
            tick();
        end
        a_vi = 1'b1;
        a_di = 8'hA3;
        for (int c = 0; c < 4; c++) begin
            #2;
            check_eq("t2_stall_ready_o", 32'(a_ro), 32'd0);
            check_eq("t2_stall_count_o", 32'(a_cnt), 32'd3);
            check_eq("t2_stall_data_o", 32'(a_do), 32'hA0);
            check_eq("t2_stall_valid_o", 32'(a_vo), 32'd1);
            tick();
        end
        a_ri = 1'b1;
        for (int c = 0; c < 6; c++) begin
            a_vi = (c < 3);
            a_di = 8'hA3 + 8'(c);
            #2;
            check_eq("t2_rel_valid_o", 32'(a_vo), 32'd1);
            check_eq("t2_rel_data_o", 32'(a_do), 32'(t2_out[c]));
            tick();
        end
        a_vi = 1'b0;
        #2;
        check_eq("t2_drained_valid_o", 32'(a_vo), 32'd0);
        check_eq("t2_drained_count_o", 32'(a_cnt), 32'd0);
        tick();

        // ---- Test 3: bubble collapse on Depth=4 ----
        b_ri = 1'b0;
        b_vi = 1'b1; b_di = 8'h11; tick();
        b_vi = 1'b0; b_di = 8'hEE; tick();
        b_vi = 1'b1; b_di = 8'h22; tick();
        b_vi = 1'b0;
        tick(); tick(); tick();
        #2;
        check_eq("t3_count_o", 32'(b_cnt), 32'd2);
        check_eq("t3_ready_o", 32'(b_ro), 32'd1);
        check_eq("t3_valid_o", 32'(b_vo), 32'd1);
        check_eq("t3_data_o", 32'(b_do), 32'h11);
        b_ri = 1'b1;
        #1;
        check_eq("t3_out0", 32'(b_do), 32'h11);
        tick();
        #2;
        check_eq("t3_out1_valid", 32'(b_vo), 32'd1);
        check_eq("t3_out1", 32'(b_do), 32'h22);
        tick();
        #2;
        check_eq("t3_empty_valid", 32'(b_vo), 32'd0);

        // ---- Test 4: flush on Depth=2 ----
        c_ri = 1'b0;
        c_vi = 1'b1; c_di = 8'h31; tick();
        c_di = 8'h32; tick();
        c_vi = 1'b0;
        #2;
        check_eq("t4_full_count_o", 32'(c_cnt), 32'd2);
        c_flush = 1'b1; c_vi = 1'b1; c_di = 8'h3F; c_ri = 1'b1;
        #2;
        check_eq("t4_flush_ready_o", 32'(c_ro), 32'd0);
        check_eq("t4_flush_valid_o", 32'(c_vo), 32'd0);
        tick();
        c_flush = 1'b0; c_vi = 1'b0;
        #2;
        check_eq("t4_post_count_o", 32'(c_cnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check_eq("t4_no_ghost_valid_o", 32'(c_vo), 32'd0);
            tick();
        end

        // ---- Test 5: reset mid-stream on Depth=2 ----
        c_ri = 1'b0;
        c_vi = 1'b1; c_di = 8'h41; tick();
        c_di = 8'h42; tick();
        c_rst = 1'b1; c_flush = 1'b1; c_vi = 1'b1; c_di = 8'h55;
        tick();
        c_rst = 1'b0; c_flush = 1'b0; c_vi = 1'b0;
        #2;
        check_eq("t5_valid_o", 32'(c_vo), 32'd0);
        check_eq("t5_data_o", 32'(c_do), 32'd0);
        check_eq("t5_count_o", 32'(c_cnt), 32'd0);
        check_eq("t5_ready_o", 32'(c_ro), 32'd1);
        c_vi = 1'b1; c_di = 8'h66; c_ri = 1'b1;
        tick();
        c_vi = 1'b0;
        #2;
        check_eq("t5_edge1_valid_o", 32'(c_vo), 32'd0);
        tick();
        #2;
        check_eq("t5_edge2_valid_o", 32'(c_vo), 32'd1);
        check_eq("t5_edge2_data_o", 32'(c_do), 32'h66);
        tick();

        // ---- Test 6: Depth=1, Bits=1 random vs scoreboard ----
        for (int c = 0; c < 1000; c++) begin
            d_vi = 1'($urandom_range(0, 1));
            d_di = 1'($urandom_range(0, 1));
            d_ri = 1'($urandom_range(0, 1));
            #2;
            exp_q = q.size();
            check_eq("t6_count_o", 32'(d_cnt), 32'(exp_q));
            check_eq("t6_valid_o", 32'(d_vo), 32'(exp_q != 0));
            check_eq("t6_ready_o", 32'(d_ro), 32'((exp_q == 0) || d_ri));
            if (d_vo && d_ri) begin
                if (exp_q == 0) begin
                    check_eq("t6_unexpected_out", 32'd1, 32'd0);
                end else begin
                    check_eq("t6_data_o", 32'(d_do), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (d_vi && d_ro) q.push_back(d_di);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
